// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares regfile write port and read port 2 between core, host debug and clear sequencer.
// Host wins against a conflicting core request once it has lost STARVE_LIMIT times in a row.
module regfile_port_arbiter #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int STARVE_LIMIT = 4,
   localparam int AW = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            core_we,
   input  logic [AW-1:0]   core_waddr,
   input  logic [XLEN-1:0] core_wdata,
   input  logic [AW-1:0]   core_ra2,
   input  logic            core_rd2_en,
   output logic            core_stall,
   input  logic            host_req,
   input  logic            host_we,
   input  logic [AW-1:0]   host_addr,
   input  logic [XLEN-1:0] host_wdata,
   output logic            host_ack,
   output logic [XLEN-1:0] host_rdata,
   input  logic            clr_req,
   output logic            clr_busy,
   output logic            rf_we3,
   output logic [AW-1:0]   rf_a3,
   output logic [XLEN-1:0] rf_wd3,
   output logic [AW-1:0]   rf_a2,
   input  logic [XLEN-1:0] rf_rd2
);
   localparam int SW = $clog2(STARVE_LIMIT + 2);
   typedef enum logic {RUN, CLEAR} state_t;
   state_t state;
   logic [AW-1:0] clr_idx;
   logic [SW-1:0] starve_cnt;
   logic ack_pend, run, conflict, host_grant, wr_host;
   assign run = state == RUN;
   assign conflict = host_we ? core_we : core_rd2_en;
   assign host_grant = rst_n & run & host_req & ~ack_pend & (~conflict | starve_cnt == SW'(STARVE_LIMIT));
   assign wr_host = host_grant & host_we;
   // reset state is RUN, so gating with rst_n keeps the port quiet while in reset
   assign rf_we3 = rst_n & (run ? (wr_host ? host_addr != '0 : core_we & (core_waddr != '0)) : 1'b1);
   assign rf_a3 = run ? (wr_host ? host_addr : core_waddr) : clr_idx;
   assign rf_wd3 = run ? (wr_host ? host_wdata : core_wdata) : '0;
   assign rf_a2 = host_grant & ~host_we ? host_addr : core_ra2;
   assign core_stall = rst_n & (run ? host_grant & conflict : 1'b1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         starve_cnt <= '0;
         clr_idx <= AW'(1);
         ack_pend <= 1'b0;
         host_ack <= 1'b0;
         host_rdata <= '0;
         clr_busy <= 1'b0;
      end else begin
         host_ack <= host_grant;
         ack_pend <= host_grant;
         if (host_grant & ~host_we)
            host_rdata <= host_addr == '0 ? '0 : rf_rd2;
         if (run) begin
            starve_cnt <= (~host_req | host_grant) ? '0 :
                          (~ack_pend & (starve_cnt != SW'(STARVE_LIMIT))) ? starve_cnt + 1'b1 : starve_cnt;
            if (clr_req) begin
               state <= CLEAR;
               clr_busy <= 1'b1;
            end
         end else begin
            clr_idx <= clr_idx == AW'(NREGS - 1) ? AW'(1) : clr_idx + 1'b1;
            if (clr_idx == AW'(NREGS - 1)) begin
               state <= RUN;
               clr_busy <= 1'b0;
            end
         end
      end
   end
endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the register file's single write port (a3/wd3/we3) and read port 2 (a2/rd2) among three users:
  - core writeback / operand-2 read;
  - a host debug port, driven by the PS over an AXI-lite bridge;
  - an internal clear sequencer that zeroes x1..x31.
- Sits between the core datapath and the regfile.
- Stalls the core whenever the port is taken, and guarantees the host makes progress through a starvation counter.

Parameters:
- XLEN, 32, data width of regfile words.
- NREGS, 32, number of architectural registers; address width is clog2(NREGS).
- STARVE_LIMIT, 4, cycles a pending host request may lose to the core before it is forced through. 0 means the host always wins.

Ports:
- clk  in  1  system clock; the regfile writes on the negedge of this same clock.
- rst_n  in  1  asynchronous active-low reset.
- core_we  in  1  core writeback request.
- core_waddr  in  5  core writeback address.
- core_wdata  in  XLEN  core writeback data.
- core_ra2  in  5  core read-port-2 address.
- core_rd2_en  in  1  core needs read port 2 this cycle.
- core_stall  out  1  core must hold its write/read this cycle and retry.
- host_req  in  1  host access request; held high until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  5  host register address.
- host_wdata  in  XLEN  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  XLEN  read data; valid while host_ack = 1.
- clr_req  in  1  start the clear sequence (level or pulse).
- clr_busy  out  1  clear sequence in progress.
- rf_we3  out  1  regfile write enable.
- rf_a3  out  5  regfile write address.
- rf_wd3  out  XLEN  regfile write data.
- rf_a2  out  5  regfile read-port-2 address.
- rf_rd2  in  XLEN  regfile read-port-2 data.

Behaviour:
- **Reset (async, rst_n = 0):**
  - state = RUN; starve_cnt = 0; clr_idx = 1; ack_pend = 0.
  - Outputs: host_ack = 0, host_rdata = 0, clr_busy = 0.
  - rf_we3 = 0 and core_stall = 0 while in reset.
  - Regfile contents are untouched, so a clear interrupted by reset leaves a partial clear.
- **State RUN, host grant:**
  - Conflict: for a host write, the conflict is core_we; for a host read, it is core_rd2_en.
  - host_grant = host_req & ~ack_pend & (~conflict | starve_cnt == STARVE_LIMIT).
- **Host write grant:**
  - rf_we3 = (host_addr != 0), rf_a3 = host_addr, rf_wd3 = host_wdata.
  - core_stall = core_we.
- **Host read grant:**
  - rf_a2 = host_addr; core_stall = core_rd2_en.
  - host_rdata is registered from rf_rd2 at the closing posedge; it reads 0 for x0.
- **No host grant:**
  - Core passes through: rf_we3 = core_we & (core_waddr != 0), rf_a3 = core_waddr, rf_wd3 = core_wdata, rf_a2 = core_ra2.
  - core_stall = 0.
- **Host handshake:**
  - host_ack pulses in the cycle after the grant; ack_pend blocks re-grant during that cycle, so peak host throughput is one access per 2 cycles.
  - The host may drop host_req after the ack, or hold it with new fields for the next access.
  - Writes to x0 are acked with no write performed.
- **starve_cnt:**
  - In RUN, increments (saturating at STARVE_LIMIT) each cycle host_req & ~ack_pend & ~host_grant.
  - Clears on grant or when host_req is low.
  - Frozen during CLEAR.
- **Clear sequence:**
  - clr_req in RUN → CLEAR at the next edge.
  - If a host grant is active in that cycle, it completes first; CLEAR is entered the cycle after, and host_ack still pulses.
  - In CLEAR: rf_we3 = 1, rf_a3 = clr_idx, rf_wd3 = 0, core_stall = 1, clr_busy = 1, no host grants.
  - clr_idx increments 1 → NREGS-1; after writing NREGS-1: clr_idx = 1, return to RUN.
  - CLEAR lasts exactly NREGS-1 = 31 cycles.
  - clr_req during CLEAR is ignored; clr_req still high on return to RUN restarts CLEAR.
- **Same-cycle read-after-write:** the regfile writes at the negedge, so a read granted in the same cycle as a write to the same address returns the new value.
- **Single driver:** the write port has exactly one driver per cycle; core and host writes are never merged.

Test Plan:
- **Reset mid-clear:** reset release, then clr_req for 1 cycle → clr_busy high for exactly 31 cycles; rf_a3 steps 1..31 with wd3 = 0; core_stall high throughout; all registers read 0 afterwards. Asserting rst_n = 0 at cycle 10 of the clear → clr_busy drops immediately; x10..x31 keep their prior values.
- **Host write, no conflict:** host write x5 = 0xDEADBEEF with core_we = 0 → rf_we3 in the grant cycle, host_ack the next cycle; a subsequent host read of x5 returns host_rdata = 0xDEADBEEF with its ack.
- **Starvation limit:** core_we held high continuously while a host write is pending → core wins 4 cycles (core_stall = 0), host is granted on the 5th with core_stall = 1; the core's held write commits the following cycle.
- **x0 handling:** host write to x0 → host_ack pulses, rf_we3 = 0; host read of x0 → host_rdata = 0. Core write to x0 → rf_we3 = 0.
- **Same-cycle read-after-write:** core writes x7 = 0x1234 in the same cycle a host read of x7 is granted (core_rd2_en = 0) → host_rdata = 0x1234.
- **Clear during host write:** clr_req in the same cycle as a host write grant → host write commits, host_ack pulses, then CLEAR runs 31 cycles; the host's next request stays pending until clr_busy falls.
